ser_link_sched: RTL and testbench

Byte scheduler for the 8-bit parallel-to-serial link. Two byte sources (channel A, channel B) compete for one serializer. The block runs link training after reset, then arbitrates between the channels once per byte slot. It presents the chosen byte, or an idle symbol, to the serializer with a one-cycle load strobe. It sits between the packet sources and the parallel-to-serial shifter; the shifter consumes one byte every `BYTE_CYCLES` clocks.

---
 rtl/ser_link_sched.sv | 138 +++++++++++++
 tb/tb_ser_link_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_link_sched.sv
// Byte scheduler: link training after reset, then one arbitration per byte slot for the serializer.
// Build option: define SCHED_RR_EN for round-robin arbitration; the default is fixed priority (A over B).
module ser_link_sched #(
   parameter logic [7:0] IDLE_SYM    = 8'hBC,
   parameter int         TRAIN_SLOTS = 4,
   parameter int         BYTE_CYCLES = 8
) (
   input  logic       CLK,
   input  logic       RESET_L,
   input  logic [7:0] DATA_A,
   input  logic       VALID_A,
   output logic       READY_A,
   input  logic [7:0] DATA_B,
   input  logic       VALID_B,
   output logic       READY_B,
   output logic [7:0] SER_DATA,
   output logic       SER_LOAD,
   output logic       SER_K,
   output logic       SER_CHAN,
   output logic       LINK_UP
);

   localparam int            SW         = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
   localparam logic [SW-1:0] SLOT_LAST  = SW'(BYTE_CYCLES - 1);
   localparam logic [7:0]    TRAIN_LAST = 8'(TRAIN_SLOTS - 1);

   typedef enum logic {TRAIN, RUN} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] slot_cnt;
   logic [7:0]    train_cnt;
   logic          decide;
   logic          grant_a, grant_b;

   assign decide = (slot_cnt == SLOT_LAST);

   // Free-running slot counter; keeps the load period fixed in both states.
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         slot_cnt <= '0;
      end else if (decide) begin
         slot_cnt <= '0;
      end else begin
         slot_cnt <= slot_cnt + SW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         train_cnt <= '0;
      end else if (state == TRAIN && decide) begin
         train_cnt <= train_cnt + 8'd1;
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state <= TRAIN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: leave TRAIN on the decision that schedules the last training slot.
   always_comb begin
      state_nxt = state;
      if (state == TRAIN && decide && train_cnt == TRAIN_LAST) begin
         state_nxt = RUN;
      end
   end

`ifdef SCHED_RR_EN
   logic last_b;

   // Last-granted pointer; starts at B so A wins the first tie.
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         last_b <= 1'b1;
      end else if (grant_a) begin
         last_b <= 1'b0;
      end else if (grant_b) begin
         last_b <= 1'b1;
      end
   end
`endif

   // Outputs: grants exist only in a RUN decision cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch can be inferred.
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == RUN && decide) begin
`ifdef SCHED_RR_EN
         if (VALID_A && VALID_B) begin
            grant_a = last_b;
            grant_b = !last_b;
         end else begin
            grant_a = VALID_A;
            grant_b = VALID_B;
         end
`else
         grant_a = VALID_A;
         grant_b = VALID_B && !VALID_A;
`endif
      end
      READY_A = grant_a;
      READY_B = grant_b;
      LINK_UP = (state == RUN);
   end

   // Serializer-facing registers: loaded on the decision edge, held until the next one.
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         SER_DATA <= 8'h00;
         SER_LOAD <= 1'b0;
         SER_K    <= 1'b0;
         SER_CHAN <= 1'b0;
      end else begin
         SER_LOAD <= decide;
         if (decide) begin
            if (grant_a) begin
               SER_DATA <= DATA_A;
               SER_K    <= 1'b0;
               SER_CHAN <= 1'b0;
            end else if (grant_b) begin
               SER_DATA <= DATA_B;
               SER_K    <= 1'b0;
               SER_CHAN <= 1'b1;
            end else begin
               SER_DATA <= IDLE_SYM;
               SER_K    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ser_link_sched.sv
// Self-checking bench for ser_link_sched: directed scenarios plus random traffic, checked every
// cycle against a slot-level reference model (training count, arbitration rule, queued sources).
module tb_ser_link_sched;

   localparam logic [7:0] IDLE  = 8'hBC;
   localparam int         TRAIN = 4;
   localparam int         BC    = 8;

   logic       CLK = 1'b0;
   logic       RESET_L = 1'b0;
   logic [7:0] data_a = 8'h00, data_b = 8'h00;
   logic       valid_a = 1'b0, valid_b = 1'b0;
   logic       ready_a, ready_b;
   logic [7:0] ser_data;
   logic       ser_load, ser_k, ser_chan, link_up;

   ser_link_sched dut (
      .CLK      (CLK),
      .RESET_L  (RESET_L),
      .DATA_A   (data_a),
      .VALID_A  (valid_a),
      .READY_A  (ready_a),
      .DATA_B   (data_b),
      .VALID_B  (valid_b),
      .READY_B  (ready_b),
      .SER_DATA (ser_data),
      .SER_LOAD (ser_load),
      .SER_K    (ser_k),
      .SER_CHAN (ser_chan),
      .LINK_UP  (link_up)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   // Source model: bytes waiting per channel and the slot position at which a new byte may appear.
   logic [7:0] qa[$], qb[$];
   int         gate_a = 0, gate_b = 0;
   bit         acc_a, acc_b;

   // Reference model state.
   int         cyc;
   int         dec_num;
   bit         last_b;
   bit         pend_load;
   logic [7:0] pend_data;
   bit         pend_k, pend_chan;
   bit         exp_load;
   logic [7:0] exp_data;
   bit         exp_k, exp_chan;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (cycle %0d after reset release)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      cyc       = 0;
      dec_num   = 0;
      last_b    = 1'b1;
      pend_load = 1'b0;
      exp_load  = 1'b0;
      exp_data  = 8'h00;
      exp_k     = 1'b0;
      exp_chan  = 1'b0;
      acc_a     = 1'b0;
      acc_b     = 1'b0;
   endtask

   // 0 = no grant, 1 = channel A, 2 = channel B.
   function automatic int winner();
      if (valid_a && valid_b) begin
`ifdef SCHED_RR_EN
         return last_b ? 1 : 2;
`else
         return 1;
`endif
      end
      if (valid_a) return 1;
      if (valid_b) return 2;
      return 0;
   endfunction

   task automatic check_cycle();
      bit dec, run;
      int w;
      dec = (cyc % BC == BC - 1);
      run = (dec_num >= TRAIN);
      w   = (dec && run) ? winner() : 0;
      check("ready_a",  {7'b0, ready_a},  {7'b0, w == 1});
      check("ready_b",  {7'b0, ready_b},  {7'b0, w == 2});
      check("ser_load", {7'b0, ser_load}, {7'b0, exp_load});
      check("link_up",  {7'b0, link_up},  {7'b0, run});
      check("ser_data", ser_data, exp_data);
      check("ser_k",    {7'b0, ser_k},    {7'b0, exp_k});
      check("ser_chan", {7'b0, ser_chan}, {7'b0, exp_chan});
   endtask

   task automatic model_decide();
      int w;
      pend_chan = exp_chan;
      if (dec_num < TRAIN) begin
         pend_data = IDLE;
         pend_k    = 1'b1;
         dec_num++;
      end else begin
         w = winner();
         if (w == 1) begin
            pend_data = data_a;
            pend_k    = 1'b0;
            pend_chan = 1'b0;
            void'(qa.pop_front());
            acc_a  = 1'b1;
            last_b = 1'b0;
         end else if (w == 2) begin
            pend_data = data_b;
            pend_k    = 1'b0;
            pend_chan = 1'b1;
            void'(qb.pop_front());
            acc_b  = 1'b1;
            last_b = 1'b1;
         end else begin
            pend_data = IDLE;
            pend_k    = 1'b1;
         end
      end
      pend_load = 1'b1;
   endtask

   task automatic drive_sources();
      if (acc_a) begin valid_a = 1'b0; acc_a = 1'b0; end
      if (acc_b) begin valid_b = 1'b0; acc_b = 1'b0; end
      if (!valid_a && qa.size() > 0 && (cyc % BC) >= gate_a) begin
         valid_a = 1'b1;
         data_a  = qa[0];
      end
      if (!valid_b && qb.size() > 0 && (cyc % BC) >= gate_b) begin
         valid_b = 1'b1;
         data_b  = qb[0];
      end
      if (!valid_a) data_a = 8'($urandom);
      if (!valid_b) data_b = 8'($urandom);
   endtask

   // One clock: check at the falling edge, update the model, advance, then drive new inputs.
   task automatic tick();
      @(negedge CLK);
      check_cycle();
      if (cyc % BC == BC - 1) model_decide();
      @(posedge CLK);
      cyc++;
      exp_load = pend_load;
      if (pend_load) begin
         exp_data = pend_data;
         exp_k    = pend_k;
         exp_chan = pend_chan;
      end
      pend_load = 1'b0;
      #1;
      drive_sources();
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic to_slot_start();
      for (int i = 0; i < BC && (cyc % BC) != 0; i++) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ser_load"}, {7'b0, ser_load}, 8'h00);
      check({tag, "_link_up"},  {7'b0, link_up},  8'h00);
      check({tag, "_ready_a"},  {7'b0, ready_a},  8'h00);
      check({tag, "_ready_b"},  {7'b0, ready_b},  8'h00);
      check({tag, "_ser_data"}, ser_data,         8'h00);
      check({tag, "_ser_k"},    {7'b0, ser_k},    8'h00);
      check({tag, "_ser_chan"}, {7'b0, ser_chan}, 8'h00);
   endtask

   task automatic release_reset();
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RESET_L = 1'b1;
      model_reset();
      drive_sources();
   endtask

   initial begin
      // Reset state with both channels requesting.
      model_reset();
      qa.push_back(8'h25);
      qb.push_back(8'h28);
      drive_sources();
      @(posedge CLK);
      #1;
      check_reset_outputs("reset");

      // Training: four idle loads, then A (tie winner) and B.
      release_reset();
      run_cycles(6 * BC);

      // Both channels continuously valid.
      to_slot_start();
      for (int i = 0; i < 4; i++) begin
         qa.push_back(8'hF9);
         qb.push_back(8'h4F);
      end
      run_cycles(9 * BC);

      // Idle fill, then a single B byte.
      to_slot_start();
      run_cycles(3 * BC);
      qb.push_back(8'hA6);
      run_cycles(2 * BC);

      // Idle-valued byte sent as data.
      to_slot_start();
      qa.push_back(IDLE);
      run_cycles(2 * BC);

      // VALID_A rising mid-slot.
      to_slot_start();
      gate_a = 3;
      qa.push_back(8'h39);
      run_cycles(2 * BC);
      gate_a = 0;

      // Random traffic with random arrival positions.
      for (int s = 0; s < 40; s++) begin
         to_slot_start();
         gate_a = int'($urandom_range(0, BC - 1));
         gate_b = int'($urandom_range(0, BC - 1));
         if ($urandom_range(0, 1) == 1) qa.push_back(8'($urandom));
         if ($urandom_range(0, 1) == 1) qb.push_back(8'($urandom));
         run_cycles(BC);
      end
      gate_a = 0;
      gate_b = 0;
      run_cycles(4 * BC);

      // Reset mid-run at slot position 5 with traffic pending.
      qa.push_back(8'h5A);
      qb.push_back(8'hC3);
      for (int i = 0; i < BC && (cyc % BC) != 5; i++) tick();
      RESET_L = 1'b0;
      #1;
      check_reset_outputs("midrst5");
      release_reset();
      run_cycles(7 * BC);

      // Reset during a load cycle.
      to_slot_start();
      RESET_L = 1'b0;
      #1;
      check_reset_outputs("midrst0");
      qa.push_back(8'h11);
      release_reset();
      run_cycles(6 * BC);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
